// File: rtl/lock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lock_fsm : combination-lock sequencer; collects a 4-digit code, evaluates  |
// |            it and tracks consecutive failures up to a permanent lockout.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module lock_fsm #(
   parameter logic [15:0] CODE      = 16'h1234,
   parameter int          MAX_FAILS = 3
) (
   input  logic       clk5,
   input  logic       reset,
   input  logic [3:0] digitIn,
   input  logic       digitValid,
   input  logic       timeUp,
   output logic [2:0] whichState,
   output logic       unlocked,
   output logic       wrongCode,
   output logic       lockedOut,
   output logic [1:0] failCount
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_GOT1    = 3'b001,
      S_GOT2    = 3'b010,
      S_GOT3    = 3'b011,
      S_EVAL    = 3'b100,
      S_CORRECT = 3'b101,
      S_WRONG   = 3'b110,
      S_LOCKOUT = 3'b111
   } state_t;

   localparam logic [1:0] c_max_fails = 2'(MAX_FAILS);
   localparam logic [1:0] c_last_fail = 2'(MAX_FAILS - 1);

   state_t     r_state;
   state_t     w_next_state;
   logic       r_err_flag;
   logic       w_next_err_flag;
   logic [1:0] r_fail_count;
   logic [1:0] w_next_fail_count;
   logic [3:0] w_code_nibble;
   logic       w_mismatch;

   always_ff @(posedge clk5) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_err_flag   <= 1'b0;
         r_fail_count <= 2'd0;
      end else begin
         r_state      <= w_next_state;
         r_err_flag   <= w_next_err_flag;
         r_fail_count <= w_next_fail_count;
      end
   end

   always_comb begin
      w_code_nibble = CODE[15:12];
      case (r_state)
         S_GOT1:  w_code_nibble = CODE[11:8];
         S_GOT2:  w_code_nibble = CODE[7:4];
         S_GOT3:  w_code_nibble = CODE[3:0];
         default: w_code_nibble = CODE[15:12];
      endcase
   end

   assign w_mismatch = (digitIn != w_code_nibble);

   always_comb begin
      w_next_state      = r_state;
      w_next_err_flag   = r_err_flag;
      w_next_fail_count = r_fail_count;
      case (r_state)
         // Every digit is taken even after a mismatch so entry timing leaks nothing.
         S_IDLE, S_GOT1, S_GOT2, S_GOT3: begin
            if (digitValid) begin
               w_next_state    = state_t'(r_state + 3'd1);
               w_next_err_flag = (r_state == S_IDLE) ? w_mismatch
                                                     : (r_err_flag | w_mismatch);
            end
         end
         S_EVAL: begin
            if (!r_err_flag) begin
               w_next_state      = S_CORRECT;
               w_next_fail_count = 2'd0;
            end else if (r_fail_count == c_last_fail) begin
               w_next_state      = S_LOCKOUT;
               w_next_fail_count = c_max_fails;
            end else begin
               w_next_state      = S_WRONG;
               w_next_fail_count = r_fail_count + 2'd1;
            end
         end
         S_CORRECT, S_WRONG: begin
            if (timeUp) begin
               w_next_state    = S_IDLE;
               w_next_err_flag = 1'b0;
            end
         end
         default: w_next_state = r_state;
      endcase
   end

   assign whichState = r_state;
   assign unlocked   = (r_state == S_CORRECT);
   assign wrongCode  = (r_state == S_WRONG);
   assign lockedOut  = (r_state == S_LOCKOUT);
   assign failCount  = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_lock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lock_fsm : directed self-checking bench for lock_fsm (CODE=16'h1234).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_lock_fsm;

   logic       clk5 = 1'b0;
   logic       reset;
   logic [3:0] digitIn;
   logic       digitValid;
   logic       timeUp;
   logic [2:0] whichState;
   logic       unlocked;
   logic       wrongCode;
   logic       lockedOut;
   logic [1:0] failCount;

   int total = 0;
   int bad   = 0;

   lock_fsm #(.CODE(16'h1234), .MAX_FAILS(3)) dut (
      .clk5       (clk5),
      .reset      (reset),
      .digitIn    (digitIn),
      .digitValid (digitValid),
      .timeUp     (timeUp),
      .whichState (whichState),
      .unlocked   (unlocked),
      .wrongCode  (wrongCode),
      .lockedOut  (lockedOut),
      .failCount  (failCount)
   );

   always #5 clk5 = ~clk5;

   task automatic tick();
      @(posedge clk5);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic [1:0] fc);
      chk({tag, ".state"}, {1'b0, whichState}, {1'b0, st});
      chk({tag, ".fail"},  {2'b0, failCount},  {2'b0, fc});
      chk({tag, ".unl"},   {3'b0, unlocked},   {3'b0, (st == 3'b101)});
      chk({tag, ".wrong"}, {3'b0, wrongCode},  {3'b0, (st == 3'b110)});
      chk({tag, ".lock"},  {3'b0, lockedOut},  {3'b0, (st == 3'b111)});
   endtask

   task automatic pulse_digit(input logic [3:0] d);
      digitIn    = d;
      digitValid = 1'b1;
      tick();
      digitValid = 1'b0;
   endtask

   task automatic pulse_time();
      timeUp = 1'b1;
      tick();
      timeUp = 1'b0;
   endtask

   // Enters four digits (gapped or back-to-back), checks EVAL, then steps one more edge.
   task automatic enter_code(input string tag, input logic [15:0] code, input bit fast);
      for (int i = 0; i < 4; i++) begin
         pulse_digit(code[15-4*i -: 4]);
         chk({tag, ".step"}, {1'b0, whichState}, 4'(i + 1));
         if (!fast) tick();
      end
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      digitIn    = 4'h0;
      digitValid = 1'b0;
      timeUp     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk_all("reset", 3'b000, 2'd0);

      // Correct code with gaps, holding between pulses
      pulse_digit(4'h1);
      chk("t1.d1", {1'b0, whichState}, 4'h1);
      tick();
      chk("t1.hold", {1'b0, whichState}, 4'h1);
      pulse_digit(4'h2);
      chk("t1.d2", {1'b0, whichState}, 4'h2);
      pulse_digit(4'h3);
      chk("t1.d3", {1'b0, whichState}, 4'h3);
      pulse_digit(4'h4);
      chk_all("t1.eval", 3'b100, 2'd0);
      tick();
      chk_all("t1.correct", 3'b101, 2'd0);
      pulse_time();
      chk_all("t1.idle", 3'b000, 2'd0);

      // Wrong third digit, no early abort
      enter_code("t2", 16'h1294, 1'b0);
      chk_all("t2.wrong", 3'b110, 2'd1);
      pulse_digit(4'h1);
      chk_all("t2.ignore", 3'b110, 2'd1);
      pulse_time();
      chk_all("t2.idle", 3'b000, 2'd1);

      // Two further failures reach lockout
      enter_code("t3a", 16'h5678, 1'b0);
      chk_all("t3.wrong2", 3'b110, 2'd2);
      pulse_time();
      enter_code("t3b", 16'h1235, 1'b1);
      chk_all("t3.lockout", 3'b111, 2'd3);
      pulse_digit(4'h1);
      pulse_time();
      tick();
      chk_all("t3.stuck", 3'b111, 2'd3);
      do_reset();
      chk_all("t3.reset", 3'b000, 2'd0);

      // Correct code after two failures clears the count
      enter_code("t4a", 16'h0000, 1'b0);
      pulse_time();
      enter_code("t4b", 16'h2234, 1'b1);
      chk_all("t4.wrong2", 3'b110, 2'd2);
      pulse_time();
      enter_code("t4c", 16'h1234, 1'b1);
      chk_all("t4.correct", 3'b101, 2'd0);
      pulse_time();
      enter_code("t4d", 16'h4321, 1'b0);
      chk_all("t4.wrong1", 3'b110, 2'd1);
      pulse_time();

      // Partial entry discarded by reset; timeUp ignored mid-entry
      pulse_digit(4'h1);
      pulse_digit(4'h2);
      pulse_time();
      chk_all("t5.tu_ignored", 3'b010, 2'd1);
      do_reset();
      chk_all("t5.reset", 3'b000, 2'd0);
      enter_code("t5", 16'h3412, 1'b0);
      chk_all("t5.wrong", 3'b110, 2'd1);

      // Simultaneous timeUp and digitValid in WRONG drops the digit
      digitIn    = 4'h1;
      digitValid = 1'b1;
      timeUp     = 1'b1;
      tick();
      digitValid = 1'b0;
      timeUp     = 1'b0;
      chk_all("t6.idle", 3'b000, 2'd1);
      tick();
      chk_all("t6.hold", 3'b000, 2'd1);
      pulse_digit(4'h1);
      chk_all("t6.got1", 3'b001, 2'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
